c1541_gcr_decoder: RTL and testbench

- Receive direction of the 1541 GCR path: consumes a serial GCR bitstream (write-head output from c1541_logic, or G64 track replay) and recovers D64 sector data.
- Detects SYNC marks, frames 10-bit GCR groups into bytes, and parses header (0x08) and data (0x07) blocks.
- Verifies the checksums and writes the 256 payload bytes into the track buffer RAM at {sector, byte}.

---
 rtl/c1541_gcr_pkg.sv | 39 +++
 rtl/c1541_gcr_framer.sv | 69 ++++++
 rtl/c1541_gcr_decoder.sv | 177 +++++++++++++++++
 tb/tb_c1541_gcr_decoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c1541_gcr_pkg.sv
// Shared GCR constants, block IDs, decoder FSM states and the 1541 zone table.
`timescale 1ns/1ps
package c1541_gcr_pkg;

  localparam logic [7:0] BLK_HDR  = 8'h08;
  localparam logic [7:0] BLK_DATA = 8'h07;

  // Index n holds the 5-bit GCR code for nibble n.
  localparam logic [15:0][4:0] GCR_ENC = {
    5'h15, 5'h1E, 5'h1D, 5'h0D, 5'h1B, 5'h1A, 5'h19, 5'h09,
    5'h17, 5'h16, 5'h0F, 5'h0E, 5'h13, 5'h12, 5'h0B, 5'h0A
  };

  typedef enum logic [2:0] {
    HUNT,
    SYNC,
    ID,
    HDR,
    DATA
  } gcr_state_e;

  // Returns {valid, nibble}; valid is 0 for the 16 illegal codes.
  function automatic logic [4:0] gcr_decode(input logic [4:0] code);
    logic [4:0] res;
    res = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (GCR_ENC[i] == code) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  function automatic logic [4:0] sectors_per_track(input logic [5:0] trk);
    if (trk < 6'd18)      return 5'd21;
    else if (trk < 6'd25) return 5'd19;
    else if (trk < 6'd31) return 5'd18;
    else                  return 5'd17;
  endfunction

endpackage

// File: rtl/c1541_gcr_framer.sv
// SYNC detector, 10-bit group shifter and GCR decode for the 1541 read path.
`timescale 1ns/1ps
module c1541_gcr_framer
  import c1541_gcr_pkg::*;
#(
  parameter int SYNC_ONES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_bit_q,
  input  logic       i_bit,
  output logic       o_sync_n,
  output logic       o_sync_det,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_code_err
);

  localparam int OW = $clog2(SYNC_ONES + 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(SYNC_ONES);

  logic [OW-1:0] r_ones;
  logic [OW-1:0] w_ones_nxt;
  logic [8:0]    r_sh;
  logic [3:0]    r_bcnt;
  logic          r_sync_n;
  logic [9:0]    w_grp;
  logic [4:0]    w_dec_hi;
  logic [4:0]    w_dec_lo;

  always_comb begin
    w_ones_nxt = '0;
    if (i_bit) w_ones_nxt = (r_ones == ONES_MAX) ? ONES_MAX : r_ones + OW'(1);
    o_sync_det   = i_bit_q & i_bit & (w_ones_nxt == ONES_MAX);
    w_grp        = {r_sh, i_bit};
    w_dec_hi     = gcr_decode(w_grp[9:5]);
    w_dec_lo     = gcr_decode(w_grp[4:0]);
    // A SYNC completing on the same bit as a group wins; the group is dropped.
    o_byte_valid = i_bit_q & r_sync_n & (r_bcnt == 4'd9) & ~o_sync_det;
    o_byte       = {w_dec_hi[3:0], w_dec_lo[3:0]};
    o_code_err   = ~(w_dec_hi[4] & w_dec_lo[4]);
  end

  assign o_sync_n = r_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones   <= '0;
      r_sh     <= '0;
      r_bcnt   <= '0;
      r_sync_n <= 1'b1;
    end else if (i_bit_q) begin
      r_ones <= w_ones_nxt;
      if (o_sync_det) begin
        r_sync_n <= 1'b0;
        r_bcnt   <= '0;
      end else if (!r_sync_n) begin
        // The 0 that ends SYNC is the MSB of the first group.
        r_sync_n <= 1'b1;
        r_sh     <= {8'b0, i_bit};
        r_bcnt   <= 4'd1;
      end else begin
        r_sh   <= w_grp[8:0];
        r_bcnt <= (r_bcnt == 4'd9) ? '0 : r_bcnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/c1541_gcr_decoder.sv
// 1541 GCR receive path: SYNC/ID/header/data parsing into the track buffer.
// Optional error counter enabled by macro C1541_GCR_DEC_STATS_EN.
`timescale 1ns/1ps
module c1541_gcr_decoder
  import c1541_gcr_pkg::*;
#(
  parameter int SYNC_ONES   = 10,
  parameter int SECTOR_BITS = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce,
  input  logic                   bit_en,
  input  logic                   bit_in,
  input  logic [5:0]             track,
  input  logic [7:0]             id1,
  input  logic [7:0]             id2,
  output logic                   sync_n,
  output logic [SECTOR_BITS+7:0] buff_addr,
  output logic [7:0]             buff_do,
  output logic                   buff_we,
  output logic [SECTOR_BITS-1:0] sector,
  output logic                   hdr_ok,
  output logic                   hdr_err,
  output logic                   data_ok,
  output logic                   data_err,
  output logic [7:0]             err_cnt
);

  logic       w_q;
  logic       w_sync_det;
  logic       w_bv;
  logic [7:0] w_byte;
  logic       w_cerr;
  logic       w_unused_ids;

  gcr_state_e r_state, w_state_nxt;
  logic [8:0] r_cnt;
  logic [7:0] r_cks, r_hsec, r_htrk, r_hid2, r_xor;
  logic       r_hdr_valid;
  logic       w_hdr_pass;
  logic       w_we, w_hok, w_herr, w_dok, w_derr;

  assign w_q          = ce & bit_en;
  assign w_unused_ids = ^{id1, id2};

  c1541_gcr_framer #(
    .SYNC_ONES(SYNC_ONES)
  ) u_framer (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_bit_q     (w_q),
    .i_bit       (bit_in),
    .o_sync_n    (sync_n),
    .o_sync_det  (w_sync_det),
    .o_byte_valid(w_bv),
    .o_byte      (w_byte),
    .o_code_err  (w_cerr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_hok       = 1'b0;
    w_herr      = 1'b0;
    w_dok       = 1'b0;
    w_derr      = 1'b0;
    w_hdr_pass  = (r_cks == (r_hsec ^ r_htrk ^ r_hid2 ^ w_byte)) &&
                  (r_htrk == {2'b00, track}) && (r_hsec < 8'd21);
    if (w_sync_det) begin
      w_state_nxt = SYNC;
    end else begin
      case (r_state)
        HUNT: ;
        SYNC: if (w_q && !bit_in) w_state_nxt = ID;
        ID: if (w_bv) begin
          if (!w_cerr && w_byte == BLK_HDR)                     w_state_nxt = HDR;
          else if (!w_cerr && w_byte == BLK_DATA && r_hdr_valid) w_state_nxt = DATA;
          else                                                   w_state_nxt = HUNT;
        end
        HDR: if (w_bv) begin
          if (w_cerr) begin
            w_herr      = 1'b1;
            w_state_nxt = HUNT;
          end else if (r_cnt == 9'd4) begin
            w_hok       = w_hdr_pass;
            w_herr      = ~w_hdr_pass;
            w_state_nxt = HUNT;
          end
        end
        DATA: if (w_bv) begin
          if (w_cerr) begin
            w_derr      = 1'b1;
            w_state_nxt = HUNT;
          end else if (!r_cnt[8]) begin
            w_we = 1'b1;
          end else begin
            w_dok       = (w_byte == r_xor);
            w_derr      = (w_byte != r_xor);
            w_state_nxt = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= HUNT;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_cks       <= '0;
      r_hsec      <= '0;
      r_htrk      <= '0;
      r_hid2      <= '0;
      r_xor       <= '0;
      r_hdr_valid <= 1'b0;
      sector      <= '0;
      buff_addr   <= '0;
      buff_do     <= '0;
      buff_we     <= 1'b0;
      hdr_ok      <= 1'b0;
      hdr_err     <= 1'b0;
      data_ok     <= 1'b0;
      data_err    <= 1'b0;
    end else begin
      buff_we  <= w_we;
      hdr_ok   <= w_hok;
      hdr_err  <= w_herr;
      data_ok  <= w_dok;
      data_err <= w_derr;
      if (w_we) begin
        buff_do   <= w_byte;
        buff_addr <= {sector, r_cnt[7:0]};
      end
      if (w_bv && !w_cerr && !w_sync_det) begin
        if (r_state == ID) begin
          r_cnt <= '0;
          r_xor <= '0;
        end else if (r_state == HDR || r_state == DATA) begin
          r_cnt <= r_cnt + 9'd1;
        end
        if (r_state == HDR) begin
          case (r_cnt)
            9'd0:    r_cks  <= w_byte;
            9'd1:    r_hsec <= w_byte;
            9'd2:    r_htrk <= w_byte;
            9'd3:    r_hid2 <= w_byte;
            default: ;
          endcase
        end
        if (r_state == DATA) r_xor <= r_xor ^ w_byte;
      end
      if (w_hok) begin
        sector      <= r_hsec[SECTOR_BITS-1:0];
        r_hdr_valid <= 1'b1;
      end
      if (w_herr || w_dok || w_derr) r_hdr_valid <= 1'b0;
    end
  end

`ifdef C1541_GCR_DEC_STATS_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     r_err_cnt <= '0;
    else if ((w_herr || w_derr) && r_err_cnt != '1)  r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_c1541_gcr_decoder.sv
// Scoreboard bench for c1541_gcr_decoder: encodes GCR streams and checks writes/pulses.
`timescale 1ns/1ps
module tb_c1541_gcr_decoder;

  logic        clk = 1'b0;
  logic        reset_n, ce, bit_en, bit_in;
  logic [5:0]  track;
  logic [7:0]  id1, id2;
  logic        sync_n;
  logic [12:0] buff_addr;
  logic [7:0]  buff_do;
  logic        buff_we;
  logic [4:0]  sector;
  logic        hdr_ok, hdr_err, data_ok, data_err;
  logic [7:0]  err_cnt;

  c1541_gcr_decoder #(
    .SYNC_ONES  (10),
    .SECTOR_BITS(5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .bit_en   (bit_en),
    .bit_in   (bit_in),
    .track    (track),
    .id1      (id1),
    .id2      (id2),
    .sync_n   (sync_n),
    .buff_addr(buff_addr),
    .buff_do  (buff_do),
    .buff_we  (buff_we),
    .sector   (sector),
    .hdr_ok   (hdr_ok),
    .hdr_err  (hdr_err),
    .data_ok  (data_ok),
    .data_err (data_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_WR = 3'd1, K_HOK = 3'd2, K_HERR = 3'd3, K_DOK = 3'd4, K_DERR = 3'd5;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [23:0] exp_q[$];
  int          exp_errs      = 0;
  logic        exp_hdr_valid = 1'b0;
  logic [4:0]  exp_sector    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ev(input logic [2:0] k, input logic [12:0] a, input logic [7:0] d);
    return {k, a, d};
  endfunction

  function automatic logic [7:0] exp_err_cnt();
`ifdef C1541_GCR_DEC_STATS_EN
    return (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [4:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 5'b01010;  4'h1: return 5'b01011;
      4'h2: return 5'b10010;  4'h3: return 5'b10011;
      4'h4: return 5'b01110;  4'h5: return 5'b01111;
      4'h6: return 5'b10110;  4'h7: return 5'b10111;
      4'h8: return 5'b01001;  4'h9: return 5'b11001;
      4'hA: return 5'b11010;  4'hB: return 5'b11011;
      4'hC: return 5'b01101;  4'hD: return 5'b11101;
      4'hE: return 5'b11110;  default: return 5'b10101;
    endcase
  endfunction

  // Scoreboard: every output event must match the head of the expected queue.
  always @(negedge clk) begin
    int          nev;
    logic [23:0] obs;
    if (reset_n) begin
      nev = int'(buff_we) + int'(hdr_ok) + int'(hdr_err) + int'(data_ok) + int'(data_err);
      if (nev > 1) check("one_event_per_clk", 64'(nev), 64'd1);
      if (nev > 0) begin
        obs = buff_we ? ev(K_WR, buff_addr, buff_do) :
              hdr_ok  ? ev(K_HOK, '0, '0) :
              hdr_err ? ev(K_HERR, '0, '0) :
              data_ok ? ev(K_DOK, '0, '0) : ev(K_DERR, '0, '0);
        if (exp_q.size() == 0) check("unexpected_event", 64'(obs), 64'hFFFF_FFFF);
        else                   check("event", 64'(obs), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    ce = 1'b1; bit_en = 1'b1; bit_in = b;
    @(posedge clk); #1;
    // strobe without ce, carrying the wrong value: must be ignored
    ce = 1'b0; bit_en = 1'b1; bit_in = ~b;
  endtask

  task automatic send_group5(input logic [4:0] g);
    for (int i = 4; i >= 0; i--) send_bit(g[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_group5(enc(b[7:4]));
    send_group5(enc(b[3:0]));
  endtask

  task automatic send_sync();
    for (int i = 0; i < 10; i++) send_bit(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ce = 1'b1; bit_en = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    idle(4);
    check(tag, 64'(exp_q.size()), 64'd0);
    check("err_cnt", 64'(err_cnt), 64'(exp_err_cnt()));
  endtask

  task automatic send_header(input logic [7:0] sec, input logic [7:0] trk);
    logic ok;
    ok = (trk == {2'b00, track}) && (sec < 8'd21);
    send_sync();
    send_byte(8'h08);
    send_byte(sec ^ trk ^ id2 ^ id1);
    send_byte(sec);
    send_byte(trk);
    send_byte(id2);
    if (ok) begin
      exp_q.push_back(ev(K_HOK, '0, '0));
      exp_hdr_valid = 1'b1;
      exp_sector    = sec[4:0];
    end else begin
      exp_q.push_back(ev(K_HERR, '0, '0));
      exp_hdr_valid = 1'b0;
      exp_errs++;
    end
    send_byte(id1);
    send_byte(8'h0F);
    send_byte(8'h0F);
  endtask

  task automatic send_data(input int n_pay, input logic [7:0] seed, input logic [7:0] cks_flip,
                           input logic do_sync);
    logic       wr;
    logic [7:0] x, d;
    wr = exp_hdr_valid;
    x  = '0;
    if (do_sync) send_sync();
    send_byte(8'h07);
    for (int i = 0; i < n_pay; i++) begin
      d = 8'(i) ^ seed;
      if (wr) exp_q.push_back(ev(K_WR, {exp_sector, 8'(i)}, d));
      x ^= d;
      send_byte(d);
    end
    if (n_pay == 256) begin
      if (wr) begin
        if (cks_flip == 8'h00) exp_q.push_back(ev(K_DOK, '0, '0));
        else begin
          exp_q.push_back(ev(K_DERR, '0, '0));
          exp_errs++;
        end
        exp_hdr_valid = 1'b0;
      end
      send_byte(x ^ cks_flip);
      send_byte(8'h55);
    end
  endtask

  initial begin
    logic [39:0] snap;
    reset_n = 1'b0; ce = 1'b0; bit_en = 1'b0; bit_in = 1'b0;
    track = 6'd1; id1 = 8'h41; id2 = 8'h42;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {sync_n, buff_addr, buff_do, buff_we, sector, hdr_ok, hdr_err,
                          data_ok, data_err, err_cnt}, {1'b1, 39'd0});
    reset_n = 1'b1;

    // 1: good header for sector 3, data 0..255, checksum 0
    send_header(8'd3, 8'd1);
    check("t1_sector", 64'(sector), 64'd3);
    send_data(256, 8'h00, 8'h00, 1'b1);
    drain("t1_drained");

    // 2: corrupted data checksum
    send_header(8'd3, 8'd1);
    send_data(256, 8'h00, 8'h01, 1'b1);
    drain("t2_drained");

    // 3: valid header, then track-mismatch header invalidates it; data ignored
    send_header(8'd7, 8'd1);
    send_header(8'd9, 8'd2);
    check("t3_sector_kept", 64'(sector), 64'd7);
    send_data(256, 8'h5A, 8'h00, 1'b1);
    drain("t3_drained");

    // 4: 9 ones are not a SYNC, 10 ones are
    send_bit(1'b0);
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    check("t4_9ones", 64'(sync_n), 64'd1);
    send_bit(1'b0);
    check("t4_9ones_then0", 64'(sync_n), 64'd1);
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    check("t4_9th_of_10", 64'(sync_n), 64'd1);
    send_bit(1'b1);
    check("t4_10ones", 64'(sync_n), 64'd0);
    send_byte(8'h00);
    check("t4_sync_released", 64'(sync_n), 64'd1);
    drain("t4_drained");

    // 5: SYNC after 100 payload bytes aborts; header survives for the next block
    send_header(8'd5, 8'd1);
    send_data(100, 8'h00, 8'h00, 1'b1);
    send_sync();
    check("t5_in_sync", 64'(sync_n), 64'd0);
    drain("t5_abort_drained");
    send_data(256, 8'hA5, 8'h00, 1'b0);
    check("t5_sector", 64'(sector), 64'd5);
    drain("t5_drained");

    // 6: invalid GCR group in header, then a stalled valid header
    send_sync();
    send_byte(8'h08);
    exp_q.push_back(ev(K_HERR, '0, '0));
    exp_hdr_valid = 1'b0;
    exp_errs++;
    send_group5(5'b00000);
    send_group5(enc(4'h1));
    drain("t6_bad_drained");
    send_sync();
    send_byte(8'h08);
    send_byte(8'd4 ^ 8'd1 ^ id2 ^ id1);
    send_byte(8'd4);
    send_byte(8'd1);
    send_group5(enc(id2[7:4]));
    snap = {sync_n, buff_addr, buff_do, buff_we, sector, hdr_ok, hdr_err, data_ok, data_err, err_cnt};
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      ce = 1'b1; bit_en = 1'b0; bit_in = 1'($urandom);
      @(negedge clk);
      check("t6_hold_stable", {sync_n, buff_addr, buff_do, buff_we, sector, hdr_ok, hdr_err,
                               data_ok, data_err, err_cnt}, snap);
    end
    send_group5(enc(id2[3:0]));
    exp_q.push_back(ev(K_HOK, '0, '0));
    exp_hdr_valid = 1'b1;
    exp_sector    = 5'd4;
    send_byte(id1);
    drain("t6_drained");
    check("t6_sector", 64'(sector), 64'd4);

    // 7: asynchronous reset in the middle of a data block
    send_data(20, 8'h3C, 8'h00, 1'b1);
    drain("t7_partial_drained");
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("t7_async_rst", {sync_n, buff_addr, buff_do, buff_we, sector, hdr_ok, hdr_err,
                           data_ok, data_err, err_cnt}, {1'b1, 39'd0});
    exp_hdr_valid = 1'b0;
    exp_sector    = '0;
    exp_errs      = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    send_data(256, 8'h11, 8'h00, 1'b1);
    drain("t7_no_hdr_drained");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
